saida_bcd_seq: RTL

// - Sequential output stage downstream of processorE's data-memory output port:

---
 rtl/saida_bcd_seq_pkg.sv | 16 +
 rtl/saida_bcd_seq_if.sv | 22 ++
 rtl/saida_bcd_seq_seg7_decoder.sv | 13 +
 rtl/saida_bcd_seq.sv | 84 ++++++++
 4 files changed

// File: rtl/saida_bcd_seq_pkg.sv
// saida_pkg: shared FSM states, 7-segment codes and the double-dabble digit adjust.
package saida_pkg;
  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [11:0] dabble(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/saida_bcd_seq_if.sv
// saida_bcd_seq_if: load/data handshake and 7-segment display bus.
interface saida_bcd_seq_if #(
  parameter int DATA_W = 32
) ();
  logic              load;
  logic [DATA_W-1:0] dado;
  logic              ready;
  logic              valid;
  logic              overflow;
  logic [6:0]        seg_sinal;
  logic [6:0]        seg_centena;
  logic [6:0]        seg_dezena;
  logic [6:0]        seg_unidade;
  modport master (
    output load, dado,
    input  ready, valid, overflow, seg_sinal, seg_centena, seg_dezena, seg_unidade
  );
  modport slave (
    input  load, dado,
    output ready, valid, overflow, seg_sinal, seg_centena, seg_dezena, seg_unidade
  );
endinterface

// File: rtl/saida_bcd_seq_seg7_decoder.sv
// seg7_decoder: combinational BCD digit to 7-segment code with selectable polarity.
module seg7_decoder
  import saida_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  logic [6:0] code;
  assign code = digit > 4'd9 ? SEG_BLANK : SEG_TABLE[digit];
  assign seg  = SEG_ACTIVE_LOW ? code : ~code;
endmodule

// File: rtl/saida_bcd_seq.sv
// saida_bcd_seq: signed word to sign + 3-digit 7-seg display via one-bit-per-clock double dabble.
module saida_bcd_seq
  import saida_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int MAG_W          = 10,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic            clock,
  input logic            reset,
  saida_bcd_seq_if.slave bus
);
  localparam logic [6:0] DASH_OUT  = SEG_ACTIVE_LOW ? SEG_DASH  : ~SEG_DASH;
  localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [6:0] ZERO_OUT  = SEG_ACTIVE_LOW ? SEG_TABLE[0] : ~SEG_TABLE[0];
  state_t            state;
  logic [DATA_W-1:0] dado_q;
  logic [DATA_W-1:0] mag_full;
  logic [MAG_W-1:0]  mag, mag_nx;
  logic [11:0]       bcd, bcd_nx;
  logic [3:0]        cnt;
  logic              neg, ovf, overflow_q;
  logic [6:0]        sinal_q, centena_q, dezena_q, unidade_q;
  logic [6:0]        dec_c, dec_d, dec_u;
  // Negation is done unsigned so the most negative input yields its true magnitude.
  assign mag_full = dado_q[DATA_W-1] ? DATA_W'(-dado_q) : dado_q;
  assign {bcd_nx, mag_nx} = {dabble(bcd), mag} << 1;
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_centena (.digit(bcd_nx[11:8]), .seg(dec_c));
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dezena  (.digit(bcd_nx[7:4]),  .seg(dec_d));
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_unidade (.digit(bcd_nx[3:0]),  .seg(dec_u));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dado_q     <= '0;
      mag        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
      overflow_q <= 1'b0;
      sinal_q    <= BLANK_OUT;
      centena_q  <= ZERO_OUT;
      dezena_q   <= ZERO_OUT;
      unidade_q  <= ZERO_OUT;
    end else begin
      case (state)
        IDLE, DONE: if (bus.load) begin
          dado_q <= bus.dado;
          state  <= ABS;
        end
        ABS: begin
          neg   <= dado_q[DATA_W-1];
          mag   <= mag_full[MAG_W-1:0];
          ovf   <= mag_full > DATA_W'(999);
          bcd   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd <= bcd_nx;
          mag <= mag_nx;
          cnt <= cnt + 4'd1;
          // Last iteration: the decoders already see the final BCD value.
          if (cnt == 4'(MAG_W - 1)) begin
            state      <= DONE;
            overflow_q <= ovf;
            sinal_q    <= neg ? DASH_OUT : BLANK_OUT;
            centena_q  <= ovf ? DASH_OUT : dec_c;
            dezena_q   <= ovf ? DASH_OUT : dec_d;
            unidade_q  <= ovf ? DASH_OUT : dec_u;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ready       = state == IDLE || state == DONE;
  assign bus.valid       = state == DONE;
  assign bus.overflow    = overflow_q;
  assign bus.seg_sinal   = sinal_q;
  assign bus.seg_centena = centena_q;
  assign bus.seg_dezena  = dezena_q;
  assign bus.seg_unidade = unidade_q;
endmodule
